// File: rtl/bus_arb_mux_pkg.sv
// Shared types and helpers for the bus_arb_mux round-robin bus multiplexer.
// The lock-state enum is only used when BUS_ARB_MUX_LOCK_EN is defined.
package bus_arb_pkg;

    typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_t;

    // Wrap is explicit so non-power-of-two channel counts work.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// found by rotating a doubled request vector so the search always starts at bit 0.
module rr_pick #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0] rot;
    logic [SEL_W:0] sum;

    // Scan downwards so the lowest set offset is the one that remains.
    always_comb begin
        rot     = N'({req, req} >> ptr);
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + (SEL_W + 1)'(k);
                gnt_idx = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : SEL_W'(sum);
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// N:1 round-robin bus multiplexer with valid/ready per channel and a registered output stage.
// Define BUS_ARB_MUX_LOCK_EN to add in_last and multi-beat packet locking.
module bus_arb_mux
    import bus_arb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              in_valid,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    output logic [N-1:0]              in_ready,
`ifdef BUS_ARB_MUX_LOCK_EN
    input  logic [N-1:0]              in_last,
`endif
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             stage_free;
    logic             accept;
    logic             adv_ptr;
    logic             pick_vld, gnt_vld;
    logic [SEL_W-1:0] pick_idx, gnt;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

`ifdef BUS_ARB_MUX_LOCK_EN
    lock_state_t      lock_state_q, lock_state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

    // While a packet is open only its owner may be granted, even if it idles.
    always_comb begin
        gnt_vld = pick_vld;
        gnt     = pick_idx;
        if (lock_state_q == LK_LOCKED) begin
            gnt_vld = in_valid[lock_ch_q];
            gnt     = lock_ch_q;
        end
    end

    always_comb begin
        lock_state_d = lock_state_q;
        lock_ch_d    = lock_ch_q;
        adv_ptr      = accept && in_last[gnt];
        case (lock_state_q)
            LK_IDLE: begin
                if (accept && !in_last[gnt]) begin
                    lock_state_d = LK_LOCKED;
                    lock_ch_d    = gnt;
                end
            end
            LK_LOCKED: begin
                if (accept && in_last[gnt]) begin
                    lock_state_d = LK_IDLE;
                end
            end
            default: lock_state_d = LK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state_q <= LK_IDLE;
            lock_ch_q    <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_ch_q    <= lock_ch_d;
        end
    end
`else
    assign gnt_vld = pick_vld;
    assign gnt     = pick_idx;
    assign adv_ptr = accept;
`endif

    // Ready is gated by reset so nothing is handshaken while the block is held.
    always_comb begin
        stage_free  = !out_valid_q || out_ready;
        accept      = stage_free && gnt_vld && !reset;
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            in_ready[gnt] = 1'b1;
            out_data_d    = in_data[gnt];
            out_sel_d     = gnt;
        end
        if (stage_free) begin
            out_valid_d = accept;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (adv_ptr) begin
            rr_ptr_d = SEL_W'(rr_next(32'(gnt), N));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux (WIDTH=8, N=16): vector table, hand sequences and
// a negedge reference model feeding a scoreboard of accepted beats. Honours BUS_ARB_MUX_LOCK_EN.
module tb_bus_arb_mux;

    localparam int WIDTH = 8;
    localparam int N     = 16;
    localparam int SEL_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          in_valid;
    logic [N-1:0][WIDTH-1:0] in_data;
    logic [N-1:0]          in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;
`ifdef BUS_ARB_MUX_LOCK_EN
    logic [N-1:0]          in_last;
`endif

    bus_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef BUS_ARB_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic         ready;
        logic [N-1:0] exp_ready;
    } vec_t;

    typedef struct {
        int               sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    vec_t  vecs[8];
    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = r;
        for (int i = 0; i < N; i++) in_data[i] = WIDTH'($urandom);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: expected handshake each cycle, scoreboard of beats in flight.
    bit           m_valid = 1'b0;
    int           m_ptr   = 0;
    bit           m_lock  = 1'b0;
    int           m_lch   = 0;
    int           m_g;
    logic         m_free;
    logic [N-1:0] m_rdy;
    beat_t        m_beat;

    always @(negedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_lock  = 1'b0;
            m_lch   = 0;
            sb.delete();
            checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        end else begin
            m_free = !m_valid || out_ready;
            if (m_lock) m_g = in_valid[m_lch] ? m_lch : -1;
            else        m_g = model_grant(in_valid, m_ptr);
            m_rdy = '0;
            if (m_free && m_g >= 0) m_rdy[m_g] = 1'b1;
            checkOutput("mon_in_ready", 32'(in_ready), 32'(m_rdy));
            checkOutput("mon_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL sb_empty: got out_valid=1 required no beat pending");
                end else begin
                    checkOutput("sb_out_data", 32'(out_data), 32'(sb[0].data));
                    checkOutput("sb_out_sel", 32'(out_sel), 32'(sb[0].sel));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (m_rdy != 0) begin
                m_beat.sel  = m_g;
                m_beat.data = in_data[m_g];
                sb.push_back(m_beat);
`ifdef BUS_ARB_MUX_LOCK_EN
                if (in_last[m_g]) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_g + 1) % N;
                end else if (!m_lock) begin
                    m_lock = 1'b1;
                    m_lch  = m_g;
                end
`else
                m_ptr = (m_g + 1) % N;
`endif
            end
            if (m_free) m_valid = (m_rdy != 0);
        end
    end

    initial begin
        int others;
        bit got;

        reset     = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef BUS_ARB_MUX_LOCK_EN
        in_last   = '1;
`endif
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sel", 32'(out_sel), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = '0;

        // Single channel
        applyStimulus(16'h0020, 1'b1);
        in_data[5] = 8'hC5;
        @(negedge clk);
        checkOutput("t2_in_ready", 32'(in_ready), 32'h0020);
        applyStimulus(16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("t2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t2_out_data", 32'(out_data), 32'hC5);
        checkOutput("t2_out_sel", 32'(out_sel), 32'd5);

        // Vector table, starting from a fresh pointer
        vecs[0] = '{16'h0020, 1'b1, 16'h0020};
        vecs[1] = '{16'h0021, 1'b1, 16'h0001};
        vecs[2] = '{16'h8002, 1'b1, 16'h0002};
        vecs[3] = '{16'h8002, 1'b1, 16'h8000};
        vecs[4] = '{16'h0000, 1'b1, 16'h0000};
        vecs[5] = '{16'h0300, 1'b0, 16'h0100};
        vecs[6] = '{16'h0300, 1'b0, 16'h0000};
        vecs[7] = '{16'h0300, 1'b1, 16'h0200};
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].ready);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
        end

        // Round-robin with wrap
        doReset();
        for (int i = 0; i <= 20; i++) begin
            applyStimulus('1, 1'b1);
            @(negedge clk);
            if (i > 0) checkOutput($sformatf("t3_sel%0d", i - 1), 32'(out_sel), 32'((i - 1) % N));
        end

        // Backpressure
        doReset();
        applyStimulus(16'h0010, 1'b1);
        in_data[4] = 8'h9C;
        @(negedge clk);
        checkOutput("t4_first_ready", 32'(in_ready), 32'h0010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('1, 1'b0);
            @(negedge clk);
            checkOutput("t4_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t4_hold_data", 32'(out_data), 32'h9C);
            checkOutput("t4_hold_sel", 32'(out_sel), 32'd4);
            checkOutput("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        applyStimulus('1, 1'b1);
        @(negedge clk);
        checkOutput("t4_resume_ready", 32'(in_ready), 32'h0020);

        // Reset while a beat is held
        applyStimulus('1, 1'b0);
        @(negedge clk);
        checkOutput("t1_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_out_sel", 32'(out_sel), 32'd0);
        checkOutput("t1_out_data", 32'(out_data), 32'd0);
        checkOutput("t1_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_in_ready_held", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Starvation bound for channel 3
        for (int r = 0; r < 4; r++) begin
            others = 0;
            got    = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                applyStimulus(N'($urandom) | 16'h0008, $urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_ready[3]) got = 1'b1;
                else if ((in_valid & in_ready) != 0) others++;
            end
            checkOutput("t5_ch3_granted", 32'(got), 32'd1);
            checkOutput("t5_wait_bound", 32'(others <= N - 1), 32'd1);
        end

`ifdef BUS_ARB_MUX_LOCK_EN
        // Packet lock: ch2 three beats, ch7 must wait
        begin
            logic [N-1:0] lv[5];
            logic         l2[5];
            logic [N-1:0] le[5];
            lv = '{16'h0084, 16'h0080, 16'h0084, 16'h0084, 16'h0080};
            l2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            le = '{16'h0004, 16'h0000, 16'h0004, 16'h0004, 16'h0080};
            doReset();
            for (int i = 0; i < 5; i++) begin
                applyStimulus(lv[i], 1'b1);
                in_last    = '1;
                in_last[2] = l2[i];
                @(negedge clk);
                checkOutput($sformatf("t6_in_ready%0d", i), 32'(in_ready), 32'(le[i]));
            end
            in_last = '1;
        end
`endif

        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
